// File: rtl/dp_ctrl_pkg.sv
// Shared types and constants for datapath_ctrl: opcodes, condition codes,
// FSM states and instruction field positions.
package dp_ctrl_pkg;

    localparam int unsigned INSTR_W = 11;

    localparam int unsigned OP_MSB   = 10;
    localparam int unsigned OP_LSB   = 8;
    localparam int unsigned RD_MSB   = 7;
    localparam int unsigned RD_LSB   = 6;
    localparam int unsigned RS1_MSB  = 5;
    localparam int unsigned RS1_LSB  = 4;
    localparam int unsigned RS2_MSB  = 3;
    localparam int unsigned RS2_LSB  = 2;
    localparam int unsigned COND_MSB = 1;
    localparam int unsigned COND_LSB = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef enum logic [1:0] {
        COND_AL = 2'b00,
        COND_EQ = 2'b01,
        COND_NE = 2'b10,
        COND_NV = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EXEC = 2'b10
    } state_e;

    function automatic logic cond_pass(input cond_e cond, input logic fz, input logic fv);
        logic ok;
        case (cond)
            COND_AL: ok = 1'b1;
            COND_EQ: ok = fz;
            COND_NE: ok = !fz;
            COND_NV: ok = !fv;
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/datapath_ctrl_instr_fifo.sv
// instr_fifo: power-of-two circular instruction buffer with a registered
// full flag, so a push is decided purely from occupancy at the clock edge.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    // full is held high during reset so nothing is accepted before the
    // first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: buffered IDLE/LOAD/EXEC sequencer driving ALU control and
// register-file ports. Conditional execution enabled by DATAPATH_CTRL_COND_EN.
module datapath_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               Zero,
    input  logic               Overflow,
    output logic [2:0]         ALUControl,
    output logic [1:0]         addr1,
    output logic [1:0]         addr2,
    output logic [1:0]         addr3,
    output logic               wr,
    output logic               busy,
    output logic               done,
    output logic               skipped,
    output logic               flag_z,
    output logic               flag_v
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               flag_z_q, flag_z_d;
    logic               flag_v_q, flag_v_d;
    logic               done_q, done_d;
    logic               skipped_q, skipped_d;
    logic               cond_ok;

    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] fifo_dout;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (instr_valid),
        .pop   (fifo_pop),
        .din   (instr),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef DATAPATH_CTRL_COND_EN
    assign cond_ok = cond_pass(cond_e'(ir_q[COND_MSB:COND_LSB]), flag_z_q, flag_v_q);
`else
    logic cond_unused;
    assign cond_unused = ^ir_q[COND_MSB:COND_LSB];
    assign cond_ok     = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        flag_z_d  = flag_z_q;
        flag_v_d  = flag_v_q;
        done_d    = 1'b0;
        skipped_d = 1'b0;
        fifo_pop  = 1'b0;
        wr        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    ir_d     = fifo_dout;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_EXEC;
            ST_EXEC: begin
                // cond_ok sees the flags as they stood on entry; the update lands at exit.
                wr = cond_ok;
                if (cond_ok) begin
                    flag_z_d = Zero;
                    flag_v_d = Overflow;
                    done_d   = 1'b1;
                end else begin
                    skipped_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            flag_z_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            done_q    <= 1'b0;
            skipped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            flag_z_q  <= flag_z_d;
            flag_v_q  <= flag_v_d;
            done_q    <= done_d;
            skipped_q <= skipped_d;
        end
    end

    assign ALUControl  = ir_q[OP_MSB:OP_LSB];
    assign addr1       = ir_q[RS1_MSB:RS1_LSB];
    assign addr2       = ir_q[RS2_MSB:RS2_LSB];
    assign addr3       = ir_q[RD_MSB:RD_LSB];
    assign instr_ready = !fifo_full;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign done        = done_q;
    assign skipped     = skipped_q;
    assign flag_z      = flag_z_q;
    assign flag_v      = flag_v_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed self-checking bench for datapath_ctrl; expectations follow
// DATAPATH_CTRL_COND_EN when conditional execution is built in.
module tb_datapath_ctrl;

`ifdef DATAPATH_CTRL_COND_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [10:0] instr;
    logic        Zero, Overflow;
    logic [2:0]  ALUControl;
    logic [1:0]  addr1, addr2, addr3;
    logic        wr, busy, done, skipped, flag_z, flag_v;

    int checks = 0;
    int errors = 0;

    datapath_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .Zero        (Zero),
        .Overflow    (Overflow),
        .ALUControl  (ALUControl),
        .addr1       (addr1),
        .addr2       (addr2),
        .addr3       (addr3),
        .wr          (wr),
        .busy        (busy),
        .done        (done),
        .skipped     (skipped),
        .flag_z      (flag_z),
        .flag_v      (flag_v)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [10:0] mk(input int k);
        return {3'(k), 2'(k % 4), 2'((k + 1) % 4), 2'((k + 2) % 4), 2'b00};
    endfunction

    // Push one instruction from idle and follow it through LOAD, EXEC and the pulse cycle.
    task automatic run_one(input string tag, input logic [10:0] ins, input logic z, input logic v,
                           input logic [2:0] e_alu, input logic [1:0] e_a1, input logic [1:0] e_a2,
                           input logic [1:0] e_a3, input logic e_wr, input logic e_fz, input logic e_fv);
        instr       = ins;
        instr_valid = 1'b1;
        Zero        = z;
        Overflow    = v;
        tick();
        instr_valid = 1'b0;
        chk({tag, "_idle_wr"}, 32'(wr), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 1);
        tick();
        chk({tag, "_load_alu"}, 32'(ALUControl), 32'(e_alu));
        chk({tag, "_load_a1"}, 32'(addr1), 32'(e_a1));
        chk({tag, "_load_a2"}, 32'(addr2), 32'(e_a2));
        chk({tag, "_load_a3"}, 32'(addr3), 32'(e_a3));
        chk({tag, "_load_wr"}, 32'(wr), 0);
        tick();
        chk({tag, "_exec_wr"}, 32'(wr), 32'(e_wr));
        chk({tag, "_exec_alu"}, 32'(ALUControl), 32'(e_alu));
        chk({tag, "_exec_a3"}, 32'(addr3), 32'(e_a3));
        tick();
        chk({tag, "_post_wr"}, 32'(wr), 0);
        chk({tag, "_done"}, 32'(done), 32'(e_wr));
        chk({tag, "_skipped"}, 32'(skipped), 32'(!e_wr));
        chk({tag, "_flag_z"}, 32'(flag_z), 32'(e_fz));
        chk({tag, "_flag_v"}, 32'(flag_v), 32'(e_fv));
        chk({tag, "_hold_alu"}, 32'(ALUControl), 32'(e_alu));
        chk({tag, "_busy_end"}, 32'(busy), 0);
        tick();
        chk({tag, "_done_off"}, 32'(done), 0);
        chk({tag, "_skipped_off"}, 32'(skipped), 0);
    endtask

    int          idx;
    int          nwr;
    bit          acc;
    bit          saw_full;
    bit          found;
    int          late_wr;
    int          late_busy;
    int          wr_cyc [8];
    logic [2:0]  wr_alu [8];
    logic [1:0]  wr_a1  [8];
    logic [1:0]  wr_a3  [8];
    logic [10:0] exp_i;

    initial begin
        rst         = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        Zero        = 1'b0;
        Overflow    = 1'b0;

        // Reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr", 32'(wr), 0);
        chk("rst_alu", 32'(ALUControl), 0);
        chk("rst_a1", 32'(addr1), 0);
        chk("rst_a2", 32'(addr2), 0);
        chk("rst_a3", 32'(addr3), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_skipped", 32'(skipped), 0);
        chk("rst_flag_z", 32'(flag_z), 0);
        chk("rst_flag_v", 32'(flag_v), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(instr_ready), 0);
        rst = 1'b1;
        #1;
        chk("rel_ready_before_edge", 32'(instr_ready), 0);
        @(negedge clk);
        chk("rel_ready_after_edge", 32'(instr_ready), 1);
        chk("rel_busy", 32'(busy), 0);

        // ADD rd=1 rs1=3 rs2=3 cond=00
        run_one("add", {3'b000, 2'd1, 2'd3, 2'd3, 2'b00}, 1'b0, 1'b0,
                3'b000, 2'd3, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
        // SUB rd=1 rs1=1 rs2=1 with Zero=1 sets flag_z
        run_one("sub", {3'b001, 2'd1, 2'd1, 2'd1, 2'b00}, 1'b1, 1'b0,
                3'b001, 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0);
        // cond=10 (!flag_z) with flag_z=1
        run_one("ne", {3'b010, 2'd2, 2'd0, 2'd1, 2'b10}, 1'b0, 1'b0,
                3'b010, 2'd0, 2'd1, 2'd2, !COND_EN, COND_EN, 1'b0);
        // cond=01 (flag_z)
        run_one("eq", {3'b011, 2'd3, 2'd2, 2'd0, 2'b01}, 1'b1, 1'b1,
                3'b011, 2'd2, 2'd0, 2'd3, 1'b1, 1'b1, 1'b1);
        // cond=11 (!flag_v) with flag_v=1
        run_one("nv", {3'b100, 2'd0, 2'd3, 2'd2, 2'b11}, 1'b0, 1'b0,
                3'b100, 2'd3, 2'd2, 2'd0, !COND_EN, COND_EN, COND_EN);

        // Six back-to-back pushes into a four-entry buffer
        Zero     = 1'b0;
        Overflow = 1'b0;
        idx      = 0;
        nwr      = 0;
        saw_full = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (wr === 1'b1 && nwr < 8) begin
                wr_cyc[nwr] = cyc;
                wr_alu[nwr] = ALUControl;
                wr_a1[nwr]  = addr1;
                wr_a3[nwr]  = addr3;
                nwr++;
            end
            if (instr_ready === 1'b0) saw_full = 1'b1;
            if (idx < 6) begin
                instr_valid = 1'b1;
                instr       = mk(idx);
                acc         = instr_ready;
            end else begin
                instr_valid = 1'b0;
                acc         = 1'b0;
            end
            tick();
            if (acc) idx++;
        end
        instr_valid = 1'b0;
        chk("b2b_pushed", 32'(idx), 6);
        chk("b2b_full_seen", 32'(saw_full), 1);
        chk("b2b_wr_count", 32'(nwr), 6);
        chk("b2b_latency", 32'(wr_cyc[0]), 3);
        for (int i = 0; i < 6; i++) begin
            exp_i = mk(i);
            chk($sformatf("b2b_alu%0d", i), 32'(wr_alu[i]), 32'(exp_i[10:8]));
            chk($sformatf("b2b_a3_%0d", i), 32'(wr_a3[i]), 32'(exp_i[7:6]));
            chk($sformatf("b2b_a1_%0d", i), 32'(wr_a1[i]), 32'(exp_i[5:4]));
            if (i > 0) chk($sformatf("b2b_gap%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 3);
        end
        chk("b2b_ready_end", 32'(instr_ready), 1);
        chk("b2b_busy_end", 32'(busy), 0);

        // Reset during EXEC with entries still queued
        for (int k = 0; k < 3; k++) begin
            instr_valid = 1'b1;
            instr       = {3'b101, 2'(k + 1), 2'd1, 2'd2, 2'b00};
            tick();
        end
        instr_valid = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 12 && !found; cyc++) begin
            if (wr === 1'b1) found = 1'b1;
            else tick();
        end
        chk("rexec_wr_seen", 32'(found), 1);
        rst = 1'b0;
        #1;
        chk("rexec_wr_falls", 32'(wr), 0);
        chk("rexec_busy", 32'(busy), 0);
        chk("rexec_ready", 32'(instr_ready), 0);
        chk("rexec_alu", 32'(ALUControl), 0);
        @(negedge clk);
        rst       = 1'b1;
        late_wr   = 0;
        late_busy = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            tick();
            if (wr !== 1'b0) late_wr++;
            if (busy !== 1'b0) late_busy++;
        end
        chk("rexec_no_late_wr", 32'(late_wr), 0);
        chk("rexec_no_late_busy", 32'(late_busy), 0);
        chk("rexec_done", 32'(done), 0);
        chk("rexec_ready_back", 32'(instr_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the instruction buffer depth in entries (power of two, >=2).
REQ-002 clk  in  1  single clock; every register SHALL update on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 instr_valid  in  1  instruction offered by the host.
REQ-005 instr_ready  out  1  buffer can accept; a transfer SHALL occur when instr_valid and instr_ready are both high at a rising edge.
REQ-006 instr  in  11  {op[10:8], rd[7:6], rs1[5:4], rs2[3:2], cond[1:0]}.
REQ-007 Zero, Overflow  in  1 each  ALU flags returned by the datapath.
REQ-008 ALUControl  out  3  ALU operation to the datapath.
REQ-009 addr1, addr2, addr3  out  2 each  read port A, read port B, write port register indices.
REQ-010 wr  out  1  register-file write enable.
REQ-011 busy  out  1  high when the FSM is not IDLE or the buffer is non-empty.
REQ-012 done, skipped  out  1 each  one-cycle completion pulses.
REQ-013 flag_z, flag_v  out  1 each  sticky condition flags.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, EXEC.
REQ-015 In IDLE with the buffer non-empty, the FSM SHALL pop the head into the instruction register and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-016 In LOAD, the outputs SHALL drive ALUControl=op, addr1=rs1, addr2=rs2, addr3=rd, with wr=0, for exactly one cycle; the FSM SHALL then go to EXEC.
REQ-017 In EXEC, the outputs SHALL hold the LOAD values, and wr SHALL equal cond_ok for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-018 cond SHALL be decoded as follows: 00 always, 01 if flag_z, 10 if !flag_z, 11 if !flag_v; cond_ok SHALL be evaluated from the flags held at entry to EXEC.
REQ-019 At the end of EXEC with cond_ok=1, flag_z<=Zero and flag_v<=Overflow; with cond_ok=0, the flags SHALL be unchanged.
REQ-020 In the cycle after EXEC, done SHALL pulse if cond_ok=1, otherwise skipped SHALL pulse; the two SHALL never both be high.
REQ-021 Throughput SHALL be one instruction per 3 cycles; minimum latency from accept to wr SHALL be 3 cycles (accept, IDLE pop, LOAD, then wr in EXEC).
REQ-022 instr_ready SHALL be high iff the buffer is not full; a simultaneous push and pop on a full buffer SHALL still be refused (ready registered from occupancy).
REQ-023 Buffer pointers SHALL wrap modulo FIFO_DEPTH, and order SHALL be strictly FIFO.
REQ-024 Outside LOAD/EXEC, ALUControl, addr1, addr2 and addr3 SHALL hold their last values, and wr SHALL be 0.

Reset
REQ-025 rst low SHALL immediately force: FSM=IDLE, buffer empty, wr=0, ALUControl=000, addr1=addr2=addr3=00, done=skipped=0, flag_z=flag_v=0, busy=0, instr_ready=0.
REQ-026 instr_ready SHALL rise at the first rising edge after rst deasserts.
REQ-027 An instruction in flight when reset is asserted SHALL be discarded with no write.

Configuration
REQ-028 With DATAPATH_CTRL_COND_EN defined, REQ-018 and REQ-019 SHALL apply as written.
REQ-029 With DATAPATH_CTRL_COND_EN undefined, cond SHALL be ignored, cond_ok SHALL be 1 always, skipped SHALL be tied to 0, and flags SHALL still update per REQ-019.

Structure
REQ-030 Package dp_ctrl_pkg SHALL hold: opcode constants (ADD=000, SUB=001, ...), cond encodings, the state enum, and instruction field bit positions.
REQ-031 The buffer SHALL be a separate sub-module, instr_fifo (parameterised depth/width, push/pop/full/empty).

Verification
REQ-032 Reset: hold rst=0 for 2 cycles -> all outputs per REQ-025; release -> instr_ready=1 next edge.
REQ-033 Push ADD rd=1, rs1=3, rs2=3, cond=00 -> LOAD drives ALUControl=000, addr1=3, addr2=3, addr3=1; wr=1 for exactly one EXEC cycle; done pulses once.
REQ-034 Then push SUB rd=1, rs1=1, rs2=1 with datapath Zero=1 -> wr pulses, and flag_z=1 after EXEC.
REQ-035 With flag_z=1, push cond=10 -> wr stays 0, skipped pulses, flags unchanged; then push cond=01 -> wr pulses and done pulses.
REQ-036 Drive 6 back-to-back pushes with FIFO_DEPTH=4 -> instr_ready drops when full; all 6 execute in push order, with wr pulses spaced 3 cycles apart.
REQ-037 Assert rst during EXEC -> wr falls within the same cycle; after release, busy=0 and the remaining queued entries are never executed.
